// File: rtl/ioctl_writer_pkg.sv
// Shared types for the ioctl -> SDRAM port1 write bridge.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Contents: wr_entry_t (one word write: address, byte enables, data), the
// issue FSM state enum, byte-enable constants and an entry constructor.
package ioctl_writer_pkg;

    // Address field is sized for the widest word address a 25-bit byte
    // address can produce; the top only drives/uses the low AW bits.
    localparam int WR_AW_MAX = 24;

    typedef struct packed {
        logic [WR_AW_MAX-1:0] addr;
        logic [1:0]           ds;    // {hi, lo} byte enables
        logic [15:0]          data;
    } wr_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } issue_state_t;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_BOTH = 2'b11;

    function automatic wr_entry_t make_entry(
        input logic [WR_AW_MAX-1:0] addr,
        input logic [1:0]           ds,
        input logic [15:0]          data
    );
        wr_entry_t e;
        e.addr = addr;
        e.ds   = ds;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/ioctl_wr_fifo.sv
// Synchronous FIFO of wr_entry_t with full/empty flags.
// Latency: an entry pushed in cycle N is visible at head in cycle N+1.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: clk/reset (sync, active-high); push/push_entry in; pop in;
// head (current oldest entry, valid when !empty); full, empty flags.
module ioctl_wr_fifo
    import ioctl_writer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wr_entry_t push_entry,
    input  logic      pop,
    output wr_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);

    wr_entry_t       mem [DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the slot being written.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/ioctl_sdram_writer.sv
// Bridges the data_io byte download stream to the SDRAM port1 toggle req/ack write port.
// Latency: word pushed to FIFO -> req toggle 1 clk after head valid; one write in flight.
// Backpressure: none upstream; FIFO full drops the entry and sets sticky overflow.
// Ports: clk_sys, reset (sync, active-high); ioctl_downl/wr/addr/dout from data_io;
// port1_req/ack/a/ds/d/we to sdram; busy, overflow status.
// Optional: IOCTL_WRITER_CKSUM_EN adds cksum[15:0], byte sum of the current download.
module ioctl_sdram_writer
    import ioctl_writer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 22
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_downl,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          port1_req,
    input  logic          port1_ack,
    output logic [AW-1:0] port1_a,
    output logic [1:0]    port1_ds,
    output logic [15:0]   port1_d,
    output logic          port1_we,
    output logic          busy,
    output logic          overflow
`ifdef IOCTL_WRITER_CKSUM_EN
    ,
    output logic [15:0]   cksum
`endif
);

    // ------------------------------------------------------------------
    // Strobe / download edge detection
    // ------------------------------------------------------------------
    logic wr_q;
    logic downl_q;
    logic strobe;
    logic flush;
    logic byte_odd;
    logic [AW-1:0] byte_word;

    assign strobe    = ioctl_downl & ioctl_wr & ~wr_q;
    assign flush     = downl_q & ~ioctl_downl;
    assign byte_odd  = ioctl_addr[0];
    // Address bits above AW are dropped: addresses wrap modulo 2^AW words.
    assign byte_word = ioctl_addr[AW:1];

    logic unused_addr_hi;
    assign unused_addr_hi = ^(ioctl_addr >> (AW + 1));

    // ------------------------------------------------------------------
    // Merge register: holds one even (lo) byte waiting for its odd partner
    // ------------------------------------------------------------------
    logic          pend_vld;
    logic [AW-1:0] pend_word;
    logic [7:0]    pend_byte;

    logic          pend_vld_nxt;
    logic [AW-1:0] pend_word_nxt;
    logic [7:0]    pend_byte_nxt;

    // Up to two entries can be produced by one byte; the second is parked
    // in hold for one cycle. Bytes are >=8 clocks apart, so hold is always
    // drained before the next byte can produce anything.
    logic      push_a;
    logic      push_b;
    wr_entry_t ent_a;
    wr_entry_t ent_b;
    logic      hold_vld;
    wr_entry_t hold_ent;

    wr_entry_t pend_ent;
    wr_entry_t pair_ent;
    wr_entry_t hi_ent;

    assign pend_ent = make_entry(WR_AW_MAX'(pend_word), DS_LO, {pend_byte, pend_byte});
    assign pair_ent = make_entry(WR_AW_MAX'(pend_word), DS_BOTH, {ioctl_dout, pend_byte});
    assign hi_ent   = make_entry(WR_AW_MAX'(byte_word), DS_HI, {ioctl_dout, ioctl_dout});

    always_comb begin
        push_a        = 1'b0;
        push_b        = 1'b0;
        ent_a         = '0;
        ent_b         = '0;
        pend_vld_nxt  = pend_vld;
        pend_word_nxt = pend_word;
        pend_byte_nxt = pend_byte;

        if (strobe) begin
            if (!byte_odd) begin
                // Even byte: any older pending byte goes out alone.
                if (pend_vld) begin
                    push_a = 1'b1;
                    ent_a  = pend_ent;
                end
                pend_vld_nxt  = 1'b1;
                pend_word_nxt = byte_word;
                pend_byte_nxt = ioctl_dout;
            end else if (pend_vld && (byte_word == pend_word)) begin
                // Odd partner of the pending even byte: one full-word write.
                push_a       = 1'b1;
                ent_a        = pair_ent;
                pend_vld_nxt = 1'b0;
            end else if (pend_vld) begin
                // Unrelated odd byte: flush pending, then this byte alone.
                push_a       = 1'b1;
                ent_a        = pend_ent;
                push_b       = 1'b1;
                ent_b        = hi_ent;
                pend_vld_nxt = 1'b0;
            end else begin
                push_a = 1'b1;
                ent_a  = hi_ent;
            end
        end else if (flush && pend_vld) begin
            push_a       = 1'b1;
            ent_a        = pend_ent;
            pend_vld_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic      fifo_push;
    wr_entry_t fifo_in;
    logic      fifo_pop;
    wr_entry_t fifo_head;
    logic      fifo_full;
    logic      fifo_empty;

    // The held entry is older than anything produced this cycle.
    assign fifo_push = hold_vld | push_a;
    assign fifo_in   = hold_vld ? hold_ent : ent_a;

    ioctl_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk_sys),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (fifo_in),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    logic unused_head_hi;
    assign unused_head_hi = ^(fifo_head.addr >> AW);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_q      <= ioctl_wr;
            downl_q   <= 1'b0;
            pend_vld  <= 1'b0;
            pend_word <= '0;
            pend_byte <= '0;
            hold_vld  <= 1'b0;
            hold_ent  <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_q      <= ioctl_wr;
            downl_q   <= ioctl_downl;
            pend_vld  <= pend_vld_nxt;
            pend_word <= pend_word_nxt;
            pend_byte <= pend_byte_nxt;
            if (hold_vld) begin
                hold_vld <= push_a;
                hold_ent <= ent_a;
            end else begin
                hold_vld <= push_b;
                hold_ent <= ent_b;
            end
            if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    // The head is copied into the port1 registers and popped at issue, so
    // the in-flight write does not occupy a FIFO slot; the registers hold
    // it stable until the ack returns.
    issue_state_t state;

    assign fifo_pop = (state == IDLE) && !fifo_empty && (port1_req == port1_ack);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            port1_req <= port1_ack;
            port1_a   <= '0;
            port1_ds  <= '0;
            port1_d   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (port1_req != port1_ack) begin
                        // Nothing is outstanding in IDLE, so a mismatch is a
                        // stale ack from a write abandoned by reset: realign.
                        port1_req <= port1_ack;
                    end else if (!fifo_empty) begin
                        port1_a   <= fifo_head.addr[AW-1:0];
                        port1_ds  <= fifo_head.ds;
                        port1_d   <= fifo_head.data;
                        port1_req <= ~port1_req;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (port1_ack == port1_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = pend_vld | hold_vld | ~fifo_empty | (port1_req != port1_ack);
    assign port1_we = ioctl_downl | busy;

    // ------------------------------------------------------------------
    // Optional download checksum
    // ------------------------------------------------------------------
`ifdef IOCTL_WRITER_CKSUM_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cksum <= '0;
        end else if (ioctl_downl && !downl_q) begin
            // New download: restart, counting a byte that lands on the edge.
            cksum <= strobe ? 16'(ioctl_dout) : 16'd0;
        end else if (strobe) begin
            cksum <= cksum + 16'(ioctl_dout);
        end
    end
`endif

endmodule
